// File: rtl/uart_axi_pkg.sv
// Shared constants, status bit positions and FSM state types for the AXI console UART.
package uart_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Status word layout: [0] full, [1] empty, [2] tx_busy, [7:3] saturated FIFO level.
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_LVL_LSB = 3;

    localparam int TX_BIT_CNT_W  = 4;
    localparam int TX_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wstate_e;

    typedef enum logic {
        RIDLE = 1'b0,
        RDATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A push while full is only legal when the same cycle frees a slot.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_uart_tx_slave.sv
// AXI4 console UART responder: write beats feed a TX FIFO drained as 8N1 frames, reads return status.
// Optional UART_SIM_PRINT_EN echoes every accepted byte to the simulator console.
module axi_uart_tx_slave
    import uart_axi_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          CLK_DIV    = 16,
    parameter logic [31:0] BASE_ADDR  = 32'ha00003f8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid,
    output logic        tx
);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout, w_byte;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       status;
    logic             unused_ok;

    assign unused_ok = ^{awsize, awburst, arsize, arburst};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (w_byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ---------------- write path ----------------
    wstate_e     wstate_q, wstate_d;
    logic        awready_q, awready_d;
    logic [2:0]  lane_q, lane_d;
    logic [3:0]  awid_q, awid_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        whit_q, whit_d;
    logic [8:0]  beats_q, beats_d, beat_cnt;
    logic [1:0]  bresp_q, bresp_d;

    assign awready = awready_q;
    assign wready  = (wstate_q == WDATA) && !fifo_full;
    assign bvalid  = (wstate_q == WRESP);
    assign bresp   = bvalid ? bresp_q : RESP_OKAY;
    assign bid     = bvalid ? awid_q : 4'd0;
    assign w_byte  = wdata[{lane_q, 3'b000} +: 8];

    always_comb begin
        wstate_d  = wstate_q;
        lane_d    = lane_q;
        awid_d    = awid_q;
        awlen_d   = awlen_q;
        whit_d    = whit_q;
        beats_d   = beats_q;
        bresp_d   = bresp_q;
        fifo_push = 1'b0;
        // Saturating so an overlong burst can never wrap back to a matching count.
        beat_cnt  = (beats_q == 9'h1FF) ? beats_q : beats_q + 9'd1;
        case (wstate_q)
            WIDLE: begin
                if (awvalid && awready_q) begin
                    wstate_d = WDATA;
                    lane_d   = awaddr[2:0];
                    awid_d   = awid;
                    awlen_d  = awlen;
                    whit_d   = (awaddr == BASE_ADDR);
                    beats_d  = 9'd0;
                end
            end
            WDATA: begin
                if (wvalid && wready) begin
                    fifo_push = whit_q && wstrb[lane_q];
                    beats_d   = beat_cnt;
                    if (wlast) begin
                        wstate_d = WRESP;
                        if (!whit_q)                                   bresp_d = RESP_DECERR;
                        else if (beat_cnt != ({1'b0, awlen_q} + 9'd1)) bresp_d = RESP_SLVERR;
                        else                                           bresp_d = RESP_OKAY;
                    end
                end
            end
            WRESP: begin
                if (bready) wstate_d = WIDLE;
            end
            default: wstate_d = WIDLE;
        endcase
        awready_d = (wstate_d == WIDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= WIDLE;
            awready_q <= 1'b0;
            lane_q    <= 3'd0;
            awid_q    <= 4'd0;
            awlen_q   <= 8'd0;
            whit_q    <= 1'b0;
            beats_q   <= 9'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            lane_q    <= lane_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
            whit_q    <= whit_d;
            beats_q   <= beats_d;
            bresp_q   <= bresp_d;
        end
    end

`ifdef UART_SIM_PRINT_EN
    always @(posedge clk) begin
        if (fifo_push) begin
            $write("%c", w_byte);
        end
    end
`endif

    // ---------------- serializer ----------------
    logic                    busy_q, busy_d;
    logic [TX_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [9:0]              shift_q, shift_d;
    logic                    baud_end, frame_end;

    assign tx        = shift_q[0];
    assign baud_end  = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign frame_end = busy_q && baud_end && (bit_cnt_q == TX_BIT_CNT_W'(TX_FRAME_BITS - 1));

    always_comb begin
        busy_d    = busy_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        // Reloading straight out of the stop bit keeps back-to-back frames gapless.
        if (!busy_q || frame_end) begin
            bit_cnt_d = '0;
            baud_d    = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                busy_d   = 1'b1;
                shift_d  = {1'b1, fifo_dout, 1'b0};
            end else begin
                busy_d  = 1'b0;
                shift_d = '1;
            end
        end else if (baud_end) begin
            baud_d    = '0;
            bit_cnt_d = bit_cnt_q + TX_BIT_CNT_W'(1);
            shift_d   = {1'b1, shift_q[9:1]};
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            shift_q   <= '1;
        end else begin
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
        end
    end

    // ---------------- read path ----------------
    rstate_e     rstate_q, rstate_d;
    logic        arready_q, arready_d;
    logic [3:0]  arid_q, arid_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        rhit_q, rhit_d;
    logic [7:0]  rbeat_q, rbeat_d;
    logic [63:0] rdata_q, rdata_d;

    always_comb begin
        status               = 8'd0;
        status[STAT_FULL]    = fifo_full;
        status[STAT_EMPTY]   = fifo_empty;
        status[STAT_BUSY]    = busy_q;
        if (32'(fifo_level) > 32'd31) status[7:STAT_LVL_LSB] = 5'd31;
        else                          status[7:STAT_LVL_LSB] = 5'(fifo_level);
    end

    assign arready = arready_q;
    assign rvalid  = (rstate_q == RDATA);
    assign rlast   = rvalid && (rbeat_q == arlen_q);
    assign rid     = rvalid ? arid_q : 4'd0;
    assign rresp   = rvalid ? (rhit_q ? RESP_OKAY : RESP_DECERR) : RESP_OKAY;
    assign rdata   = rvalid ? rdata_q : 64'd0;

    always_comb begin
        rstate_d = rstate_q;
        arid_d   = arid_q;
        arlen_d  = arlen_q;
        rhit_d   = rhit_q;
        rbeat_d  = rbeat_q;
        rdata_d  = rdata_q;
        // Each beat's data is captured when it is launched, so it holds while rready is low.
        case (rstate_q)
            RIDLE: begin
                if (arvalid && arready_q) begin
                    rstate_d = RDATA;
                    arid_d   = arid;
                    arlen_d  = arlen;
                    rhit_d   = (araddr == BASE_ADDR);
                    rbeat_d  = 8'd0;
                    rdata_d  = (araddr == BASE_ADDR) ? {8{status}} : 64'd0;
                end
            end
            RDATA: begin
                if (rready) begin
                    if (rbeat_q == arlen_q) begin
                        rstate_d = RIDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = rhit_q ? {8{status}} : 64'd0;
                    end
                end
            end
            default: rstate_d = RIDLE;
        endcase
        arready_d = (rstate_d == RIDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q  <= RIDLE;
            arready_q <= 1'b0;
            arid_q    <= 4'd0;
            arlen_q   <= 8'd0;
            rhit_q    <= 1'b0;
            rbeat_q   <= 8'd0;
            rdata_q   <= 64'd0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            rhit_q    <= rhit_d;
            rbeat_q   <= rbeat_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_uart_tx_slave.sv
// Directed bench for axi_uart_tx_slave: AXI drivers, a serial-line frame decoder and immediate-assert checks.
module tb_axi_uart_tx_slave;

    localparam int          CLK_DIV = 16;
    localparam logic [31:0] BASE    = 32'ha00003f8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    int         rxt_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_uart_tx_slave #(
        .FIFO_DEPTH (16),
        .CLK_DIV    (CLK_DIV),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),     .rst_n   (rst_n),
        .awready (awready), .awvalid (awvalid), .awaddr (awaddr), .awid (awid),
        .awlen   (awlen),   .awsize  (awsize),  .awburst (awburst),
        .wready  (wready),  .wvalid  (wvalid),  .wdata  (wdata),  .wstrb (wstrb), .wlast (wlast),
        .bvalid  (bvalid),  .bready  (bready),  .bresp  (bresp),  .bid   (bid),
        .arready (arready), .arvalid (arvalid), .araddr (araddr), .arid  (arid),
        .arlen   (arlen),   .arsize  (arsize),  .arburst (arburst),
        .rvalid  (rvalid),  .rready  (rready),  .rresp  (rresp),  .rdata (rdata),
        .rlast   (rlast),   .rid     (rid),
        .tx      (tx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Serial decoder: every bit must hold for exactly CLK_DIV samples; aborted frames count as errors.
    initial begin : rx_mon
        logic [9:0] bits;
        logic       first;
        logic       ok;
        int         st;
        step();
        forever begin
            if (tx === 1'b0 && rst_n === 1'b1) begin
                st = cyc;
                ok = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    first   = tx;
                    bits[b] = first;
                    for (int c = 1; c < CLK_DIV; c++) begin
                        step();
                        if (tx !== first || rst_n !== 1'b1) ok = 1'b0;
                    end
                    step();
                    if (rst_n !== 1'b1) ok = 1'b0;
                end
                if (ok && bits[0] == 1'b0 && bits[9] == 1'b1) begin
                    rx_q.push_back(bits[8:1]);
                    rxt_q.push_back(st);
                end else begin
                    frame_err++;
                end
            end else begin
                step();
            end
        end
    end

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n;
        awaddr = a; awid = id; awlen = len; awsize = 3'd0; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 100) begin step(); n++; end
        chk("aw_handshake", 64'(n < 100), 64'd1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [7:0] b, input logic [7:0] strb, input logic last, output int stall);
        int n;
        wdata = {56'hDEAD_BEEF_CAFE_F0, b}; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        while (wready !== 1'b1 && n < 500) begin step(); n++; end
        chk("w_handshake", 64'(n < 500), 64'd1);
        stall = n;
        step();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait(input logic [1:0] exp_resp, input logic [3:0] exp_id, input int hold);
        int n;
        int unstable;
        bready = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 100) begin step(); n++; end
        chk("b_valid", 64'(bvalid), 64'd1);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bvalid !== 1'b1 || bresp !== exp_resp || bid !== exp_id) unstable++;
        end
        chk("b_hold", 64'(unstable), 64'd0);
        chk("bresp", 64'(bresp), 64'(exp_resp));
        chk("bid", 64'(bid), 64'(exp_id));
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_drop", 64'(bvalid), 64'd0);
        chk("awready_back", 64'(awready), 64'd1);
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n;
        araddr = a; arid = id; arlen = len; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 100) begin step(); n++; end
        chk("ar_handshake", 64'(n < 100), 64'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] exp_data, input logic exp_last, input logic [3:0] exp_id,
                          input logic [1:0] exp_resp, input int hold);
        int unstable;
        chk("rvalid", 64'(rvalid), 64'd1);
        chk("rdata", rdata, exp_data);
        chk("rlast", 64'(rlast), 64'(exp_last));
        chk("rid", 64'(rid), 64'(exp_id));
        chk("rresp", 64'(rresp), 64'(exp_resp));
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (rvalid !== 1'b1 || rdata !== exp_data) unstable++;
        end
        chk("r_hold", 64'(unstable), 64'd0);
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin step(); k++; end
        chk("rx_count", 64'(rx_q.size()), 64'(n));
    endtask

    initial begin : stim
        logic [7:0] burst2 [4];
        int st, stall_sum, hcyc, t0;
        burst2[0] = 8'h48; burst2[1] = 8'h69; burst2[2] = 8'h21; burst2[3] = 8'h0A;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

        // Reset state
        repeat (3) step();
        chk("rst_handshakes", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_ids_resps", 64'({bresp, bid, rresp, rid}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle_readys", 64'({awready, arready}), 64'b11);

        // 1: single write of 'A'
        aw_send(BASE, 4'h3, 8'd0);
        chk("t1_wready_lat", 64'(wready), 64'd1);
        chk("t1_awready_low", 64'(awready), 64'd0);
        w_send(8'h41, 8'h01, 1'b1, st);
        hcyc = cyc;
        chk("t1_bvalid_lat", 64'(bvalid), 64'd1);
        b_wait(2'b00, 4'h3, 0);
        wait_rx(1, 400);
        chk("t1_byte", 64'(rx_q.pop_front()), 64'h41);
        chk("t1_pop_time", 64'(rxt_q.pop_front()), 64'(hcyc + 1));
        chk("t1_tx_idle", 64'(tx), 64'd1);

        // 2: four-beat burst, bready held low
        aw_send(BASE, 4'h7, 8'd3);
        for (int i = 0; i < 4; i++) w_send(burst2[i], 8'h01, i == 3, st);
        b_wait(2'b00, 4'h7, 5);
        wait_rx(4, 1000);
        t0 = rxt_q[0];
        for (int i = 0; i < 4; i++) begin
            chk("t2_byte", 64'(rx_q.pop_front()), 64'(burst2[i]));
            chk("t2_start", 64'(rxt_q.pop_front()), 64'(t0 + i * 160));
        end

        // 3: 20-beat burst overflows the 16-entry FIFO
        aw_send(BASE, 4'h1, 8'd19);
        stall_sum = 0;
        for (int i = 0; i < 20; i++) begin
            w_send(8'h30 + 8'(i), 8'h01, i == 19, st);
            stall_sum += st;
        end
        chk("t3_stalled", 64'(stall_sum > 100), 64'd1);
        b_wait(2'b00, 4'h1, 0);
        wait_rx(20, 3500);
        chk("t3_span", 64'(rxt_q[19] - rxt_q[0]), 64'(19 * 160));
        for (int i = 0; i < 20; i++) chk("t3_byte", 64'(rx_q[i]), 64'(8'h30 + 8'(i)));
        rx_q.delete(); rxt_q.delete();

        // 4: decode error, short burst, long burst, masked strobe
        aw_send(32'ha0000000, 4'h2, 8'd0);
        w_send(8'h77, 8'h01, 1'b1, st);
        b_wait(2'b11, 4'h2, 0);
        aw_send(BASE, 4'h4, 8'd1);
        w_send(8'h55, 8'h01, 1'b1, st);
        b_wait(2'b10, 4'h4, 0);
        aw_send(BASE, 4'h5, 8'd0);
        w_send(8'h56, 8'h01, 1'b0, st);
        w_send(8'h57, 8'h01, 1'b1, st);
        b_wait(2'b10, 4'h5, 0);
        aw_send(BASE, 4'h6, 8'd0);
        w_send(8'h99, 8'hFE, 1'b1, st);
        b_wait(2'b00, 4'h6, 0);
        wait_rx(3, 800);
        repeat (200) step();
        chk("t4_only3", 64'(rx_q.size()), 64'd3);
        chk("t4_b0", 64'(rx_q.pop_front()), 64'h55);
        chk("t4_b1", 64'(rx_q.pop_front()), 64'h56);
        chk("t4_b2", 64'(rx_q.pop_front()), 64'h57);
        rxt_q.delete();

        // 5: status reads (idle, then while draining, then a decode error)
        ar_send(BASE, 4'h9, 8'd0);
        r_beat({8{8'h02}}, 1'b1, 4'h9, 2'b00, 0);
        chk("t5_rvalid_done", 64'(rvalid), 64'd0);
        aw_send(BASE, 4'hA, 8'd2);
        w_send(8'h61, 8'h01, 1'b0, st);
        w_send(8'h62, 8'h01, 1'b0, st);
        w_send(8'h63, 8'h01, 1'b1, st);
        b_wait(2'b00, 4'hA, 0);
        ar_send(BASE, 4'h5, 8'd1);
        r_beat({8{8'h14}}, 1'b0, 4'h5, 2'b00, 170);
        r_beat({8{8'h0C}}, 1'b1, 4'h5, 2'b00, 0);
        chk("t5_rvalid_end", 64'(rvalid), 64'd0);
        ar_send(32'ha0000008, 4'h6, 8'd0);
        r_beat(64'd0, 1'b1, 4'h6, 2'b11, 0);
        wait_rx(3, 600);
        chk("t5_b0", 64'(rx_q.pop_front()), 64'h61);
        chk("t5_b1", 64'(rx_q.pop_front()), 64'h62);
        chk("t5_b2", 64'(rx_q.pop_front()), 64'h63);
        rxt_q.delete();
        chk("frame_err_pre_rst", 64'(frame_err), 64'd0);

        // 6: reset mid-frame and mid-burst
        aw_send(BASE, 4'hB, 8'd3);
        w_send(8'h11, 8'h01, 1'b0, st);
        w_send(8'h22, 8'h01, 1'b0, st);
        repeat (40) step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", 64'(tx), 64'd1);
        chk("t6_rst_handshakes", 64'({awready, wready, bvalid, arready, rvalid}), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (200) step();
        chk("t6_aborted", 64'(frame_err), 64'd1);
        chk("t6_no_rx", 64'(rx_q.size()), 64'd0);
        aw_send(BASE, 4'hC, 8'd0);
        w_send(8'h5A, 8'h01, 1'b1, st);
        b_wait(2'b00, 4'hC, 0);
        wait_rx(1, 400);
        chk("t6_byte", 64'(rx_q.pop_front()), 64'h5A);
        chk("t6_frame_err", 64'(frame_err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
